fft_frame_feeder: RTL and testbench

//  Source end of the FFT stream. Gathers mono audio samples into N_POINTS-sample frames in a

---
 rtl/fft_frame_feeder.sv | 173 +++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: collects mono audio samples into N_POINTS-sample frames held in a
// ping-pong RAM and streams each complete frame to the FFT core as valid/ready/last beats.
// Each beat carries the real sample in the low half and zero imaginary in the high half.
//
// Read FSM states:
//   state    | meaning
//   S_IDLE   | waiting for the read bank to become FULL; issues RAM read of word 0
//   S_FETCH  | word 0 lands in the output register, word 1 is prefetched
//   S_STREAM | beats presented; each handshake advances to the prefetched word
//
// Bank FULL/EMPTY flags are the only interlock between writer and reader.
module fft_frame_feeder #(
    parameter int N_POINTS = 1024,
    parameter int SAMPLE_W = 16,
    parameter int DROP_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_count,
    output logic                frame_done
);

    localparam int              AW       = $clog2(N_POINTS);
    localparam logic [AW-1:0]   LAST_IDX = AW'(N_POINTS - 1);
    localparam logic [AW-1:0]   PENULT   = AW'(N_POINTS - 2);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    logic [SAMPLE_W-1:0] mem_q [2*N_POINTS];
    logic [SAMPLE_W-1:0] rd_word_q;

    logic [1:0]          full_q, full_d;
    logic                wr_bank_q;
    logic [AW-1:0]       wr_idx_q;
    logic                overflow_q;
    logic [DROP_W-1:0]   drop_q;

    state_t              state_q;
    logic                rd_bank_q;
    logic [AW-1:0]       rd_addr_q;
    logic [AW-1:0]       beat_q;
    logic [SAMPLE_W-1:0] out_sample_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                frame_done_q;

    logic                beat_hs;
    logic                rd_free;
    logic                wr_free;
    logic                wr_en;
    logic                wr_done;
    logic                ram_re;
    logic [AW-1:0]       ram_idx;

    // Handshake, bank interlock and RAM read-port control.
    always_comb begin
        beat_hs = out_valid_q && out_ready;
        rd_free = (state_q == S_STREAM) && beat_hs && out_last_q;
        // A bank being released this cycle is already writable this cycle.
        wr_free = !full_q[wr_bank_q] || (rd_free && (rd_bank_q == wr_bank_q));
        wr_en   = sample_valid && wr_free;
        wr_done = wr_en && (wr_idx_q == LAST_IDX);

        full_d = full_q;
        if (rd_free) full_d[rd_bank_q] = 1'b0;
        if (wr_done) full_d[wr_bank_q] = 1'b1;

        ram_re  = 1'b0;
        ram_idx = rd_addr_q;
        case (state_q)
            S_IDLE: begin
                ram_re  = full_q[rd_bank_q];
                ram_idx = '0;
            end
            S_FETCH:  ram_re = 1'b1;
            S_STREAM: ram_re = beat_hs && !out_last_q;
            default:  ram_re = 1'b0;
        endcase
    end

    // Ping-pong sample RAM: one write port, one registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[{wr_bank_q, wr_idx_q}] <= sample_in;
        if (ram_re) rd_word_q <= mem_q[{rd_bank_q, ram_idx}];
    end

    // Write side: bank fill, bank flags and drop accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            full_q     <= full_d;
            overflow_q <= sample_valid && !wr_free;
            if (wr_en) wr_idx_q <= wr_done ? '0 : wr_idx_q + 1'b1;
            if (wr_done) wr_bank_q <= ~wr_bank_q;
            if (sample_valid && !wr_free && (drop_q != DROP_MAX)) drop_q <= drop_q + 1'b1;
        end
    end

    // Read FSM with registered beat outputs; rd_word_q acts as the one-word skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rd_bank_q    <= 1'b0;
            rd_addr_q    <= '0;
            beat_q       <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        rd_addr_q <= AW'(1);
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    out_sample_q <= rd_word_q;
                    out_valid_q  <= 1'b1;
                    out_last_q   <= 1'b0;
                    beat_q       <= '0;
                    rd_addr_q    <= rd_addr_q + 1'b1;
                    state_q      <= S_STREAM;
                end
                S_STREAM: begin
                    if (beat_hs) begin
                        if (out_last_q) begin
                            out_valid_q  <= 1'b0;
                            out_last_q   <= 1'b0;
                            out_sample_q <= '0;
                            frame_done_q <= 1'b1;
                            rd_bank_q    <= ~rd_bank_q;
                            state_q      <= S_IDLE;
                        end else begin
                            out_sample_q <= rd_word_q;
                            out_last_q   <= (beat_q == PENULT);
                            beat_q       <= beat_q + 1'b1;
                            rd_addr_q    <= rd_addr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_data   = {{(32-SAMPLE_W){1'b0}}, out_sample_q};
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: drives ramps and random samples, captures every output
// handshake and compares the beat stream against an expected list built from the samples
// the writer should have accepted.
module tb_fft_frame_feeder;

    localparam int N = 1024;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic [15:0] sample_in    = '0;
    logic        sample_valid = 1'b0;
    logic        out_ready    = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        overflow;
    logic [15:0] drop_count;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ready_mode = 0;   // 0: hold low, 1: hold high, 2: random 50%

    logic [31:0] cap_data[$];
    logic        cap_last[$];
    logic [15:0] exp_q[$];
    int model_acc, model_drop;
    int ovf_cnt, fd_cnt, stall_err, imag_err, first_valid_cyc, last_sample_cyc;

    always #5 clk = ~clk;

    fft_frame_feeder #(.N_POINTS(N), .SAMPLE_W(16), .DROP_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .frame_done   (frame_done)
    );

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Output monitor on the falling edge: handshakes, pulses and stall stability.
    initial begin
        logic [31:0] pd;
        logic        pl;
        logic        ps;
        pd = '0; pl = 1'b0; ps = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ps = 1'b0;
            end else begin
                if (out_valid && out_data[31:16] != 16'h0) imag_err++;
                if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (ps && (!out_valid || out_data !== pd || out_last !== pl)) stall_err++;
                if (out_valid && out_ready) begin
                    cap_data.push_back(out_data);
                    cap_last.push_back(out_last);
                end
                if (overflow)   ovf_cnt++;
                if (frame_done) fd_cnt++;
                ps = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
            end
        end
    end

    task automatic clear_mon();
        cap_data.delete();
        cap_last.delete();
        ovf_cnt = 0; fd_cnt = 0; stall_err = 0; imag_err = 0;
        first_valid_cyc = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_acc = 0;
        model_drop = 0;
        exp_q.delete();
        clear_mon();
        @(posedge clk);
        #1;
    endtask

    // Reference: every accepted sample becomes the next beat. With the reader blocked,
    // two complete frames fill both banks and anything after that is lost.
    task automatic feed(input int count, input int start, input bit rnd,
                        input int gap_lo, input int gap_hi);
        logic [15:0] v;
        for (int i = 0; i < count; i++) begin
            v = rnd ? 16'($urandom) : 16'(start + i);
            sample_in = v;
            sample_valid = 1'b1;
            last_sample_cyc = cyc;
            if (ready_mode == 0 && model_acc >= 2*N) begin
                model_drop++;
            end else begin
                exp_q.push_back(v);
                model_acc++;
            end
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
            repeat ($urandom_range(gap_lo, gap_hi) - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c = 0;
        while (cap_data.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Number of beats that disagree with the expected stream (missing/extra beats included).
    function automatic int stream_errs();
        int e;
        int m;
        e = (cap_data.size() > exp_q.size()) ? cap_data.size() - exp_q.size()
                                              : exp_q.size() - cap_data.size();
        m = (cap_data.size() < exp_q.size()) ? cap_data.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            if (cap_data[i] !== {16'h0000, exp_q[i]} || cap_last[i] !== ((i % N) == N-1)) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_last, overflow, frame_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000", {out_valid, out_last, overflow, frame_done});
        end
        n_tests++;
        if (out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 00000000", out_data);
        end
        n_tests++;
        if (drop_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_drop: got %0d required 0", drop_count);
        end
        do_reset();
    endtask

    task automatic test_ramp();
        int e;
        do_reset();
        ready_mode = 1;
        feed(N, 0, 1'b0, 1, 1);
        wait_beats(N, 3000);
        n_tests++;
        if (cap_data.size() !== N) begin
            n_fail++;
            $display("FAIL ramp_count: got %0d beats required %0d", cap_data.size(), N);
        end
        e = stream_errs();
        n_tests++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL ramp_stream: %0d bad beats, required 0", e);
        end
        n_tests++;
        if (first_valid_cyc - last_sample_cyc !== 3) begin
            n_fail++;
            $display("FAIL ramp_latency: got %0d cycles required 3", first_valid_cyc - last_sample_cyc);
        end
        n_tests++;
        if (fd_cnt !== 1) begin
            n_fail++;
            $display("FAIL ramp_frame_done: got %0d required 1", fd_cnt);
        end
        n_tests++;
        if (ovf_cnt !== 0) begin
            n_fail++;
            $display("FAIL ramp_overflow: got %0d required 0", ovf_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        do_reset();
        ready_mode = 1;
        feed(2*N, 0, 1'b0, 4, 4);
        wait_beats(2*N, 3000);
        e = stream_errs();
        n_tests++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL b2b_stream: %0d bad beats (got %0d beats) required 0", e, cap_data.size());
        end
        n_tests++;
        if (ovf_cnt !== 0 || drop_count !== 16'h0) begin
            n_fail++;
            $display("FAIL b2b_overflow: got %0d pulses drop_count %0d required 0", ovf_cnt, drop_count);
        end
        n_tests++;
        if (fd_cnt !== 2) begin
            n_fail++;
            $display("FAIL b2b_frame_done: got %0d required 2", fd_cnt);
        end
    endtask

    task automatic test_random_ready();
        int e;
        do_reset();
        ready_mode = 2;
        feed(N, 0, 1'b0, 1, 1);
        feed(N, 0, 1'b1, 1, 2);
        wait_beats(2*N, 8000);
        e = stream_errs();
        n_tests++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL rready_stream: %0d bad beats (got %0d beats) required 0", e, cap_data.size());
        end
        n_tests++;
        if (stall_err !== 0) begin
            n_fail++;
            $display("FAIL rready_stable: %0d unstable stalls required 0", stall_err);
        end
        n_tests++;
        if (fd_cnt !== 2 || ovf_cnt !== 0) begin
            n_fail++;
            $display("FAIL rready_pulses: frame_done %0d overflow %0d required 2 and 0", fd_cnt, ovf_cnt);
        end
    endtask

    task automatic test_overflow();
        int e;
        do_reset();
        ready_mode = 0;
        feed(2*N + 5, 0, 1'b0, 1, 1);
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (ovf_cnt !== model_drop) begin
            n_fail++;
            $display("FAIL ovf_pulses: got %0d required %0d", ovf_cnt, model_drop);
        end
        n_tests++;
        if (drop_count !== 16'(model_drop)) begin
            n_fail++;
            $display("FAIL ovf_drop_count: got %0d required %0d", drop_count, model_drop);
        end
        n_tests++;
        if (out_valid !== 1'b1 || cap_data.size() !== 0) begin
            n_fail++;
            $display("FAIL ovf_stalled: out_valid %b beats %0d required 1 and 0", out_valid, cap_data.size());
        end
        ready_mode = 1;
        wait_beats(2*N, 5000);
        e = stream_errs();
        n_tests++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL ovf_stream: %0d bad beats (got %0d beats) required 0", e, cap_data.size());
        end
        n_tests++;
        if (fd_cnt !== 2 || stall_err !== 0) begin
            n_fail++;
            $display("FAIL ovf_release: frame_done %0d stalls %0d required 2 and 0", fd_cnt, stall_err);
        end
    endtask

    task automatic test_negative();
        int e;
        do_reset();
        ready_mode = 1;
        feed(1, 16'hFFFF, 1'b0, 1, 1);
        feed(N-1, 0, 1'b1, 1, 3);
        wait_beats(N, 3000);
        n_tests++;
        if (cap_data.size() == 0 || cap_data[0] !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL neg_first: got %h required 0000ffff", (cap_data.size() == 0) ? 32'hx : cap_data[0]);
        end
        n_tests++;
        if (imag_err !== 0) begin
            n_fail++;
            $display("FAIL neg_imag: %0d beats with nonzero imag required 0", imag_err);
        end
        e = stream_errs();
        n_tests++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL neg_stream: %0d bad beats required 0", e);
        end
    endtask

    task automatic test_reset_mid_frame();
        int e;
        int c;
        do_reset();
        ready_mode = 1;
        feed(N, 0, 1'b0, 1, 1);
        c = 0;
        while (cap_data.size() < 300 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        n_tests++;
        if (cap_data.size() < 300) begin
            n_fail++;
            $display("FAIL midrst_reach: got %0d beats required 300", cap_data.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_last, overflow, frame_done} !== 4'b0000 || out_data !== 32'h0 || drop_count !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: valid %b last %b data %h drop %0d required all 0",
                     out_valid, out_last, out_data, drop_count);
        end
        do_reset();
        feed(N, 0, 1'b0, 1, 1);
        wait_beats(N, 3000);
        e = stream_errs();
        n_tests++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL midrst_stream: %0d bad beats (got %0d beats) required 0", e, cap_data.size());
        end
        n_tests++;
        if (fd_cnt !== 1) begin
            n_fail++;
            $display("FAIL midrst_frame_done: got %0d required 1", fd_cnt);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_ramp();
        test_back_to_back();
        test_random_ready();
        test_overflow();
        test_negative();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
